// File: rtl/demux1to8_reg.sv
// Registered 1-to-8 demultiplexer: one holding stage with valid/ready on both sides.
// Optional per-destination delivery counters are built when DEMUX_STATS_EN is defined.

module demux1to8_lane #(
  parameter int IDX = 0
) (
`ifdef DEMUX_STATS_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       stat_clr,
  output logic [7:0] count,
`endif
  input  logic       full,
  input  logic [2:0] sel_q,
  input  logic       ready,
  output logic       valid,
  output logic       dlv
);
  localparam logic [2:0] MY_SEL = 3'(IDX);

  assign valid = full & (sel_q == MY_SEL);
  assign dlv   = valid & ready;

`ifdef DEMUX_STATS_EN
  // Clear has priority over a same-edge delivery; the counter wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (stat_clr) count <= '0;
    else if (dlv)      count <= count + 8'd1;
  end
`endif
endmodule

module demux1to8_reg #(
  parameter int WIDTH = 128,
  parameter int NDEST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [NDEST-1:0] out_valid,
  input  logic [NDEST-1:0] out_ready,
  output logic             busy
`ifdef DEMUX_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [8*NDEST-1:0] stat_count
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       sel;
  } hold_t;

  state_t           state, state_nxt;
  hold_t            hold_q;
  logic [NDEST-1:0] dlv;
  logic             deliver, accept;

  assign deliver = |dlv;
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept)                state_nxt = FULL;
      FULL:    if (deliver && !accept)    state_nxt = EMPTY;
      default:                            state_nxt = EMPTY;
    endcase
  end

  // in_ready stays low during reset so nothing is accepted into a clearing stage.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      in_ready = (state == EMPTY) | deliver;
      busy     = (state == FULL);
    end
  end

  // Data is only written on accept; after a plain deliver it keeps the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         hold_q <= '0;
    else if (accept) hold_q <= '{data: in_data, sel: in_sel};
  end

  assign out_data = hold_q.data;

  for (genvar k = 0; k < NDEST; k++) begin : g_lane
    demux1to8_lane #(.IDX(k)) u_lane (
`ifdef DEMUX_STATS_EN
      .clk      (clk),
      .rst      (rst),
      .stat_clr (stat_clr),
      .count    (stat_count[8*k +: 8]),
`endif
      .full     (state == FULL),
      .sel_q    (hold_q.sel),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .dlv      (dlv[k])
    );
  end
endmodule

// File: tb/tb_demux1to8_reg.sv
// Directed + random bench for demux1to8_reg against a one-entry queue model.
module tb_demux1to8_reg;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic [2:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic         busy;
`ifdef DEMUX_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_count;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: a queue holding at most one pending word.
  typedef struct { logic [127:0] data; int sel; } word_t;
  word_t        q[$];
  logic [127:0] last_data;
  int           cnt[8];
  int           deliveries_after_rst;

  demux1to8_reg #(.WIDTH(128), .NDEST(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
`ifdef DEMUX_STATS_EN
    , .stat_clr(stat_clr), .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    q.delete();
    last_data = '0;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
  endtask

  function automatic logic exp_ready();
    if (rst) return 1'b0;
    if (q.size() == 0) return 1'b1;
    return out_ready[q[0].sel];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ev;
    ev = (q.size() != 0) ? (8'h01 << q[0].sel) : 8'h00;
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(ev));
    chk({tag, ".busy"}, 128'(busy), 128'(q.size() != 0));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(exp_ready()));
    chk({tag, ".out_data"}, out_data, (q.size() != 0) ? q[0].data : last_data);
`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 8; i++)
      chk({tag, ".stat"}, 128'(stat_count[8*i +: 8]), 128'(cnt[i]));
`endif
  endtask

  // Advance one edge: model consumes the inputs presented before the edge.
  task automatic tick(input string tag);
    logic dl, ac;
    @(posedge clk);
    if (!rst) begin
      dl = (q.size() != 0) && out_ready[q[0].sel];
      ac = in_valid && ((q.size() == 0) || dl);
`ifdef DEMUX_STATS_EN
      if (stat_clr) for (int i = 0; i < 8; i++) cnt[i] = 0;
      else if (dl) cnt[q[0].sel] = (cnt[q[0].sel] + 1) % 256;
`endif
      if (dl) begin
        deliveries_after_rst++;
        void'(q.pop_front());
      end
      if (ac) begin
        q.push_back('{data: in_data, sel: int'(in_sel)});
        last_data = in_data;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [127:0] d,
                       input logic [7:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, 8'h00);
`ifdef DEMUX_STATS_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    deliveries_after_rst = 0;
    #2;
    check_all("reset");
    tick("reset_hold");
    rst = 1'b0;
    #1;
    check_all("reset_release");

    // Sweep: back-to-back words, one per destination.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 128'(8'hA0 + k), 8'hFF);
      #1; chk("sweep.in_ready_pre", 128'(in_ready), 128'(1'b1));
      tick("sweep");
      chk("sweep.onehot", 128'(out_valid), 128'(8'h01 << k));
      chk("sweep.data", out_data, 128'(8'hA0 + k));
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick("sweep_drain");

    // Backpressure on destination 3.
    drive(1'b1, 3'd3, 128'h55, 8'hF7);
    tick("bp_accept");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), rnd128(), 8'hF7);
      #1; chk("bp.in_ready", 128'(in_ready), 128'(1'b0));
      tick("bp_stall");
      chk("bp.valid", 128'(out_valid), 128'(8'h08));
      chk("bp.data", out_data, 128'h55);
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick("bp_release");

    // Every ready except the selected one.
    drive(1'b1, 3'd5, rnd128(), 8'hDF);
    tick("wr_accept");
    drive(1'b0, 3'd0, '0, 8'hDF);
    for (int i = 0; i < 4; i++) tick("wrong_ready");
    chk("wr.busy", 128'(busy), 128'(1'b1));
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick("wr_release");

    // Mid-cycle reset while a word is held.
    drive(1'b1, 3'd2, 128'h77, 8'h00);
    tick("rf_accept");
    drive(1'b0, 3'd0, '0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rf_async");
    tick("rf_hold");
    rst = 1'b0;
    deliveries_after_rst = 0;
    out_ready = 8'hFF;
    #1;
    for (int i = 0; i < 4; i++) tick("rf_after");
    chk("rf.no_delivery", 128'(deliveries_after_rst), 128'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd128(),
            8'($urandom_range(0, 255)) | (($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00));
`ifdef DEMUX_STATS_EN
      stat_clr = ($urandom_range(0, 31) == 0);
`endif
      tick("rand");
    end

`ifdef DEMUX_STATS_EN
    drive(1'b0, 3'd0, '0, 8'hFF);
    stat_clr = 1'b1;
    tick("st_clr");
    stat_clr = 1'b0;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 3'd6, rnd128(), 8'hFF);
      tick("st_fill");
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick("st_last");
    chk("stats.wrap", 128'(stat_count[55:48]), 128'(8'd1));
    drive(1'b1, 3'd6, rnd128(), 8'hFF);
    tick("st_load");
    drive(1'b0, 3'd0, '0, 8'hFF);
    stat_clr = 1'b1;
    tick("st_clr_dlv");
    stat_clr = 1'b0;
    chk("stats.clr_wins", 128'(stat_count[55:48]), 128'(8'd0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
